// File: rtl/dense_argmax.sv
`default_nettype none
// ============================================================================
//  Module   : dense_argmax
//  Purpose  : Output-decision stage after the dense layer. Tracks the running
//             maximum of each NUM_CLASSES-long frame of signed sums and
//             presents the winning class index/score on a ready/valid port.
//  Option   : define DENSE_ARGMAX_RELU_EN to clamp negative sums to zero
//             before comparison (score is then always >= 0).
//  Revision : 1.0  - initial release
// ============================================================================
module dense_argmax #(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_W      = 16,
  parameter int IDX_W       = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic signed [DATA_W-1:0] sum_in,
  input  logic                     sum_valid,
  output logic        [IDX_W-1:0]  class_idx,
  output logic signed [DATA_W-1:0] class_score,
  output logic                     class_valid,
  input  logic                     class_ready,
  output logic                     busy,
  output logic                     overrun
);

  // Index of the final sum of a frame.
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t                     r_state;
  state_t                     w_state_next;
  logic        [IDX_W-1:0]    r_cnt;
  logic        [IDX_W-1:0]    w_cnt_next;

  logic signed [DATA_W-1:0]   r_max;
  logic        [IDX_W-1:0]    r_idx;
  logic signed [DATA_W-1:0]   r_score;
  logic        [IDX_W-1:0]    r_out_idx;
  logic                       r_overrun;

  logic                       w_handshake;
  logic                       w_can_accept;
  logic                       w_accept;
  logic                       w_drop;
  logic                       w_last;
  logic                       w_take;
  logic signed [DATA_W-1:0]   w_sum_eff;
  logic signed [DATA_W-1:0]   w_max_next;
  logic        [IDX_W-1:0]    w_idx_next;

`ifdef DENSE_ARGMAX_RELU_EN
  // Negative sums never beat zero: clamp before the compare.
  assign w_sum_eff = sum_in[DATA_W-1] ? '0 : sum_in;
`else
  assign w_sum_eff = sum_in;
`endif

  // A pending result blocks new sums unless it is being consumed this cycle,
  // in which case the sum becomes element 0 of the next frame (no bubble).
  assign w_handshake  = (r_state == ST_HOLD) & class_ready;
  assign w_can_accept = (r_state == ST_ACCUM) | class_ready;
  assign w_accept     = ena & sum_valid & w_can_accept;
  assign w_drop       = ena & sum_valid & (r_state == ST_HOLD) & ~class_ready;

  // Strict signed compare keeps the lower index on ties; element 0 seeds.
  assign w_last     = (r_cnt == C_LAST_IDX);
  assign w_take     = (r_cnt == '0) | (w_sum_eff > r_max);
  assign w_max_next = w_take ? w_sum_eff : r_max;
  assign w_idx_next = w_take ? r_cnt : r_idx;

  // State and per-frame counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_ACCUM;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state and counter decode.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_ACCUM: begin
        if (w_accept) begin
          if (w_last) begin
            w_cnt_next   = '0;
            w_state_next = ST_HOLD;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (w_handshake) begin
          w_state_next = ST_ACCUM;
        end
        if (w_accept) begin
          // Counter is zero here; a frame of at least two sums cannot end on
          // this element, but keep the general path for completeness.
          if (w_last) begin
            w_cnt_next   = '0;
            w_state_next = ST_HOLD;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_next = ST_ACCUM;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Running max tracker and output result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_max     <= '0;
      r_idx     <= '0;
      r_score   <= '0;
      r_out_idx <= '0;
    end else if (w_accept) begin
      r_max <= w_max_next;
      r_idx <= w_idx_next;
      if (w_last) begin
        r_score   <= w_max_next;
        r_out_idx <= w_idx_next;
      end
    end
  end

  // Sticky overrun: a sum arrived while a result was pending and not taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end
  end

  assign class_idx   = r_out_idx;
  assign class_score = r_score;
  assign class_valid = (r_state == ST_HOLD);
  assign busy        = (r_cnt != '0);
  assign overrun     = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_dense_argmax.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dense_argmax
//  Purpose  : Self-checking bench for dense_argmax using a table of frames
//             with hand-computed winners plus directed multi-cycle sequences.
//  Revision : 1.0  - initial release
// ============================================================================
module tb_dense_argmax;

  localparam int NUM_CLASSES = 10;
  localparam int DATA_W      = 16;
  localparam int IDX_W       = 4;

  logic                     clk;
  logic                     rst_n;
  logic                     ena;
  logic signed [DATA_W-1:0] sum_in;
  logic                     sum_valid;
  logic        [IDX_W-1:0]  class_idx;
  logic signed [DATA_W-1:0] class_score;
  logic                     class_valid;
  logic                     class_ready;
  logic                     busy;
  logic                     overrun;

  int n_tests = 0;
  int n_fail  = 0;

  dense_argmax #(
    .NUM_CLASSES (NUM_CLASSES),
    .DATA_W      (DATA_W),
    .IDX_W       (IDX_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .sum_in      (sum_in),
    .sum_valid   (sum_valid),
    .class_idx   (class_idx),
    .class_score (class_score),
    .class_valid (class_valid),
    .class_ready (class_ready),
    .busy        (busy),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int s [10];
    int idx;
    int score;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input int v, input int idx, input int score);
    chk({name, "_valid"}, int'(class_valid), v);
    chk({name, "_idx"}, int'(class_idx), idx);
    chk({name, "_score"}, int'(class_score), score);
  endtask

  initial begin
    int acc;
    int frame_a [10];
    int frame_b [10];

    // Frame table: sums with hand-derived winners.
    vecs[0].s = '{3, -7, 12, 5, 12, 0, 1, 2, 4, 9};
    vecs[0].idx = 2;  vecs[0].score = 12;
    vecs[1].s = '{-5, -3, -9, -4, -8, -6, -7, -10, -12, -20};
`ifdef DENSE_ARGMAX_RELU_EN
    vecs[1].idx = 0;  vecs[1].score = 0;
`else
    vecs[1].idx = 1;  vecs[1].score = -3;
`endif
    vecs[2].s = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 100};
    vecs[2].idx = 9;  vecs[2].score = 100;
    vecs[3].s = '{50, 50, -1, 50, 0, 0, 0, 0, 0, 50};
    vecs[3].idx = 0;  vecs[3].score = 50;
    vecs[4].s = '{-32768, 0, 0, 0, 0, 32767, 32767, -1, 0, 0};
    vecs[4].idx = 5;  vecs[4].score = 32767;
    vecs[5].s = '{-1, -2, -3, 0, -4, -5, -6, -7, -8, -9};
`ifdef DENSE_ARGMAX_RELU_EN
    vecs[5].idx = 0;  vecs[5].score = 0;
`else
    vecs[5].idx = 3;  vecs[5].score = 0;
`endif

    rst_n = 1'b0; ena = 1'b1; sum_in = '0; sum_valid = 1'b0; class_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_out("reset", 0, 0, 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_overrun", int'(overrun), 0);

    // Table-driven frames, consumer always ready.
    for (int v = 0; v < 6; v++) begin
      for (int k = 0; k < NUM_CLASSES; k++) begin
        @(negedge clk);
        if (k == 1) chk($sformatf("v%0d_busy_mid", v), int'(busy), 1);
        if (k == 9) chk($sformatf("v%0d_prevalid", v), int'(class_valid), 0);
        sum_in = DATA_W'(vecs[v].s[k]); sum_valid = 1'b1;
      end
      @(negedge clk);
      sum_valid = 1'b0;
      chk_out($sformatf("v%0d", v), 1, vecs[v].idx, vecs[v].score);
      chk($sformatf("v%0d_busy", v), int'(busy), 0);
      @(negedge clk);
      chk($sformatf("v%0d_drop_valid", v), int'(class_valid), 0);
    end

    // Backpressure: hold result 20 cycles, then a dropped sum sets overrun.
    class_ready = 1'b0;
    for (int k = 0; k < NUM_CLASSES; k++) begin
      @(negedge clk);
      sum_in = DATA_W'(vecs[2].s[k]); sum_valid = 1'b1;
    end
    @(negedge clk);
    sum_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      chk_out($sformatf("bp_hold%0d", c), 1, 9, 100);
      @(negedge clk);
    end
    sum_in = 16'sd777; sum_valid = 1'b1;
    @(negedge clk);
    sum_valid = 1'b0;
    chk("bp_overrun", int'(overrun), 1);
    chk("bp_busy", int'(busy), 0);
    chk_out("bp_after_drop", 1, 9, 100);
    class_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", int'(class_valid), 0);
    chk("bp_overrun_sticky", int'(overrun), 1);

    // Mid-frame reset: partial frame with a big value must be discarded.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      sum_in = (k == 2) ? 16'sd500 : 16'sd1; sum_valid = 1'b1;
    end
    @(negedge clk);
    sum_valid = 1'b0;
    chk("mr_busy_pre", int'(busy), 1);
    rst_n = 1'b0;
    #2;
    chk_out("mr_reset", 0, 0, 0);
    chk("mr_busy", int'(busy), 0);
    chk("mr_overrun", int'(overrun), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < NUM_CLASSES; k++) begin
      @(negedge clk);
      sum_in = DATA_W'(vecs[0].s[k]); sum_valid = 1'b1;
    end
    @(negedge clk);
    sum_valid = 1'b0;
    chk_out("mr_fresh", 1, 2, 12);
    @(negedge clk);

    // Back-to-back frames, no gap, ready high.
    frame_a = vecs[0].s;
    frame_b = vecs[3].s;
    for (int i = 0; i < 2 * NUM_CLASSES; i++) begin
      @(negedge clk);
      if (i == NUM_CLASSES) chk_out("b2b_a", 1, 2, 12);
      if (i == NUM_CLASSES + 1) chk("b2b_a_drop", int'(class_valid), 0);
      if (i == NUM_CLASSES - 1) chk("b2b_a_pre", int'(class_valid), 0);
      sum_in = DATA_W'((i < NUM_CLASSES) ? frame_a[i] : frame_b[i - NUM_CLASSES]);
      sum_valid = 1'b1;
    end
    @(negedge clk);
    sum_valid = 1'b0;
    chk_out("b2b_b", 1, 0, 50);
    chk("b2b_overrun", int'(overrun), 0);
    @(negedge clk);

    // ena gating: cycles 3..5 carry junk that would win if accepted.
    acc = 0;
    for (int c = 0; c < NUM_CLASSES + 3; c++) begin
      @(negedge clk);
      if (c > 0 && c < NUM_CLASSES + 2)
        chk($sformatf("ena_novalid%0d", c), int'(class_valid), 0);
      if (c == 4) chk("ena_busy_hold", int'(busy), 1);
      sum_valid = 1'b1;
      ena = !(c >= 3 && c <= 5);
      if (ena) begin
        sum_in = DATA_W'(vecs[0].s[acc]);
        acc++;
      end else begin
        sum_in = 16'sd999;
      end
    end
    @(negedge clk);
    sum_valid = 1'b0; ena = 1'b1;
    chk_out("ena_frame", 1, 2, 12);
    chk("ena_overrun", int'(overrun), 0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dense_argmax.md
# dense_argmax

Output-decision stage placed directly downstream of the dense layer. It consumes the stream of signed 16-bit neuron sums (`dense_sum_out` / `valid`), one per output class. For each frame of `NUM_CLASSES` sums it tracks the running maximum and its index, then presents the winning class on a ready/valid output port. Results are held until the consumer (UART/LED/host readout) accepts them.

## Interface
- `NUM_CLASSES`, default 10: number of sums per frame, one per class; legal range 2..256.
- `DATA_W`, default 16: width of the signed sum input and the score output.
- `IDX_W`, default 4: class index width; must satisfy 2^IDX_W >= NUM_CLASSES.
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst_n`  in  1: reset, asynchronous assert, active-low.
- `ena`  in  1: block enable; when low, no sum is accepted and the state machine holds.
- `sum_in`  in  DATA_W: signed dense sum; connects to dense `dense_sum_out`.
- `sum_valid`  in  1: `sum_in` is valid this cycle; connects to dense `valid`.
- `class_idx`  out  IDX_W: index of the winning class.
- `class_score`  out  DATA_W: signed score of the winning class.
- `class_valid`  out  1: result is available.
- `class_ready`  in  1: consumer accepts the result.
- `busy`  out  1: a frame is partially accumulated (count != 0).
- `overrun`  out  1: sticky flag; a sum was dropped while a result was pending.

## Operation
- **Accept rule:** a sum is accepted when `ena & sum_valid` and the FSM can take it (see below).
- **FSM states:**
  - `ACCUM`: collecting sums.
  - `HOLD`: result presented, awaiting handshake.
- **Per-frame counter** `cnt`: 0..NUM_CLASSES-1.
- **In ACCUM, on an accepted sum:**
  - If `cnt == 0`: `max <= sum`, `idx <= 0`.
  - Else if `sum > max` (signed, strict): `max <= sum`, `idx <= cnt`.
  - Ties keep the lower index.
  - If `cnt == NUM_CLASSES-1`: load the output registers from the final comparison (including the current sum), set `cnt <= 0`, move to HOLD. Otherwise `cnt <= cnt + 1`.
- **In HOLD:**
  - `class_valid = 1`; `class_idx` and `class_score` are stable until the handshake.
  - Handshake occurs when `class_valid & class_ready`; the FSM returns to ACCUM.
- **Sum arriving in HOLD:**
  - If `class_ready` is high in the same cycle, the sum is accepted as element 0 of the next frame, with no bubble.
  - Otherwise the sum is dropped and `overrun <= 1`.
- **`ena` low:** no accept and no counter change. An output handshake in HOLD still completes.
- **Flags:** `overrun` is cleared only by reset. `busy = (cnt != 0)`.
- **Arithmetic:** pure signed compare at DATA_W. No arithmetic on the data path, so no overflow is possible.

## Timing
- **Reset values:** `class_idx = 0`, `class_score = 0`, `class_valid = 0`, `busy = 0`, `overrun = 0`; FSM = ACCUM, `cnt = 0`.
- **Latency:** last sum accepted at edge t → `class_valid` high after edge t, i.e. 1 cycle.
- **Throughput:** one sum per cycle. Back-to-back frames sustain it if `class_ready` is high on the cycle after each frame's last sum.
- **`class_valid` deassertion:** it falls on the edge following the handshake. If the next frame's last sum lands on that same edge, it stays high with the new result.
- **Reset mid-frame:** partial frame discarded, pending result discarded.

## Configuration
- **`DENSE_ARGMAX_RELU_EN` defined:** each accepted sum is clamped to 0 if negative before comparison. `class_score` is therefore >= 0; an all-negative frame yields idx 0, score 0.
- **Not defined:** raw signed sums are compared; `class_score` may be negative.

## Test plan
- **Basic frame:** sums 3, -7, 12, 5, 12, 0, 1, 2, 4, 9 with `class_ready=1` → 1 cycle after the 10th sum: `class_valid=1`, `class_idx=2`, `class_score=12` (tie at index 4 ignored).
- **All negative:** -5, -3, -9, ... (max -3 at index 1).
  - Without macro → idx 1, score -3.
  - With `DENSE_ARGMAX_RELU_EN` → idx 0, score 0.
- **Backpressure:** `class_ready=0` for 20 cycles after a result → outputs stable. Then send 1 sum with `class_ready=0` → sum dropped, `overrun=1`, `busy=0`. Release ready → `class_valid` drops next cycle.
- **Back-to-back:** two 10-sum frames with no gap, ready high → two results, each 1 cycle after its last sum, no dropped sums, `overrun=0`.
- **`ena` gating:** toggle `ena` low during frame sums 4–6 while `sum_valid` stays high → those sums ignored; the frame completes only after 10 accepted sums.
- **Mid-frame reset:** assert `rst_n=0` after 5 sums → all outputs at reset values. The next 10 sums form a fresh frame with a correct result.
